// File: rtl/minesweeper_pkg.sv
// Shared constants for the minesweeper data-port responder.
// MMIO map, STATUS bit positions, LFSR polynomial and button indices.
package minesweeper_pkg;

    localparam logic [7:0] MMIO_BASE   = 8'hF0;
    localparam logic [7:0] ADDR_STATUS = 8'hF0;
    localparam logic [7:0] ADDR_BTNEV  = 8'hF1;
    localparam logic [7:0] ADDR_RAND   = 8'hF2;
    localparam logic [7:0] ADDR_LED    = 8'hF3;

    localparam int STATUS_NONEMPTY = 0;
    localparam int STATUS_FULL     = 1;
    localparam int STATUS_OVF      = 2;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    localparam int NUM_BTNS   = 5;
    localparam int BTN_UP     = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_CENTER = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_DOWN   = 4;

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/data_mem_responder_debounce.sv
// One push button: 2-FF synchronizer, stability counter and press pulse.
// press is high on the edge where a 0->1 change is accepted.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic btnRaw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          settle;

    assign settle = (sync2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign press  = settle & sync2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= btnRaw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (settle) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: 240 B RAM plus MMIO page (button FIFO, LFSR, LED).
// Reads are combinational from ADDR; every side effect lands on posedge CLK.
module data_mem_responder
    import minesweeper_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] ADDR,
    input  logic [7:0] WDATA,
    input  logic       MW,
    input  logic       RD,
    output logic [7:0] RDATA,
    input  logic [4:0] BTN,
    output logic [7:0] LED
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    logic [7:0]          ram [0:239];
    logic [2:0]          fifoMem [FIFO_DEPTH];
    logic [PW-1:0]       rdPtr;
    logic [PW-1:0]       wrPtr;
    logic [CNTW-1:0]     count;
    logic                ovf;
    logic [15:0]         lfsr;
    logic [NUM_BTNS-1:0] pending;
    logic [NUM_BTNS-1:0] press;
    logic [NUM_BTNS-1:0] grant;
    logic [2:0]          grantCode;

    logic isRam;
    logic nonEmpty;
    logic full;
    logic push;
    logic pop;
    logic drop;
    logic accept;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : gBtn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uDebounce (
            .CLK   (CLK),
            .RESET (RESET),
            .btnRaw(BTN[i]),
            .press (press[i])
        );
    end

    assign isRam    = ADDR < MMIO_BASE;
    assign nonEmpty = count != '0;
    assign full     = count == CNTW'(FIFO_DEPTH);
    assign push     = |pending;
    assign pop      = RD && (ADDR == ADDR_BTNEV) && nonEmpty;
    assign drop     = push && full && !pop;
    assign accept   = push && !drop;

    // Lowest pending index wins; one event per cycle.
    always_comb begin
        grant     = '0;
        grantCode = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant     = NUM_BTNS'(1) << i;
                grantCode = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (MW && isRam && !RESET) begin
            ram[ADDR] <= WDATA;
        end
        if (accept) begin
            fifoMem[wrPtr] <= grantCode;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            LED     <= '0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            lfsr    <= LFSR_SEED;
            pending <= '0;
        end else begin
            if (MW && ADDR == ADDR_LED) begin
                LED <= WDATA;
            end
            lfsr <= (MW && ADDR == ADDR_RAND) ? {8'hA5, WDATA}
                                                : lfsrStep(lfsr);
            if (accept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + CNTW'(accept) - CNTW'(pop);
            // A drop on the same edge as a clear leaves the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (MW && ADDR == ADDR_STATUS && WDATA[STATUS_OVF]) begin
                ovf <= 1'b0;
            end
            pending <= (pending & ~grant) | press;
        end
    end

    always_comb begin
        RDATA = '0;
        if (isRam) begin
            RDATA = ram[ADDR];
        end else begin
            case (ADDR)
                ADDR_STATUS: RDATA = {5'b0, ovf, full, nonEmpty};
                ADDR_BTNEV:  RDATA = nonEmpty ? {5'b0, fifoMem[rdPtr]} : 8'h00;
                ADDR_RAND:   RDATA = lfsr[7:0];
                ADDR_LED:    RDATA = LED;
                default:     RDATA = '0;
            endcase
        end
    end

endmodule
